// File: rtl/fixed_point_vector_unit.sv
// fixed_point_vector_unit: multi-lane fixed-point vector pipe with vxrm/vxsat.
// Define FXP_SMUL_EN to build in the SMUL multiplier; otherwise SMUL is illegal.
module fixed_point_vector_unit #(
    parameter int ELEN  = 32,
    parameter int LANES = 2,
    parameter int VL_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            op,
    input  logic [1:0]            sew,
    input  logic [1:0]            vxrm,
    input  logic [VL_W-1:0]       vl,
    input  logic                  vm,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*ELEN-1:0] in_a,
    input  logic [LANES*ELEN-1:0] in_b,
    input  logic [LANES*ELEN-1:0] in_old,
    input  logic [LANES-1:0]      in_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*ELEN-1:0] out_data,
    input  logic                  clr_vxsat,
    output logic                  vxsat,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal
);
    localparam int W       = 2 * ELEN + 2;
    localparam int DW      = $clog2(2 * ELEN);
    localparam int EW      = VL_W + 2;
    localparam int SEW_MAX = $clog2(ELEN / 8);

    localparam logic [3:0] SADDU = 4'd0, SADD = 4'd1, SSUBU = 4'd2, SSUB = 4'd3;
    localparam logic [3:0] AADDU = 4'd4, AADD = 4'd5, ASUBU = 4'd6, ASUB = 4'd7;
    localparam logic [3:0] SMUL = 4'd8, SSRL = 4'd9, SSRA = 4'd10;
    localparam logic [3:0] NCLIPU = 4'd11, NCLIP = 4'd12;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [W-1:0] sh;
        logic         half;
        logic         low;
    } raw_t;

    function automatic logic signed [W-1:0] ext(
        input logic [2*ELEN-1:0] x, input int bits, input logic sgn);
        logic signed [W-1:0] t;
        t = {2'b00, x} << (W - bits);
        return sgn ? (t >>> (W - bits)) : (t >> (W - bits));
    endfunction

    function automatic raw_t lane_s1(
        input logic [ELEN-1:0] a, input logic [ELEN-1:0] b,
        input logic [3:0] o, input logic [1:0] s);
        int sb;
        int d;
        logic sg;
        logic nc;
        logic signed [W-1:0] va;
        logic signed [W-1:0] vb;
        logic signed [W-1:0] v;
        logic [W-1:0] hm;
`ifdef FXP_SMUL_EN
        logic signed [ELEN:0] ma;
        logic signed [ELEN:0] mb;
`endif
        raw_t r;
        sb = 8 << s;
        sg = (o == SADD) || (o == SSUB) || (o == AADD) || (o == ASUB) ||
             (o == SMUL) || (o == SSRA) || (o == NCLIP);
        nc = (o == NCLIPU) || (o == NCLIP);
        va = ext({{ELEN{1'b0}}, a}, nc ? 2 * sb : sb, sg);
        vb = ext({{ELEN{1'b0}}, b}, sb, sg);
`ifdef FXP_SMUL_EN
        ma = va[ELEN:0];
        mb = vb[ELEN:0];
`endif
        v = '0;
        d = 0;
        unique case (1'b1)
            (o == SADDU || o == SADD): v = va + vb;
            (o == SSUBU || o == SSUB): v = va - vb;
            (o == AADDU || o == AADD): begin
                v = va + vb;
                d = 1;
            end
            (o == ASUBU || o == ASUB): begin
                v = va - vb;
                d = 1;
            end
`ifdef FXP_SMUL_EN
            (o == SMUL): begin
                v = W'(ma) * W'(mb);
                d = sb - 1;
            end
`endif
            (o == SSRL || o == SSRA): begin
                v = va;
                d = int'(b[DW-1:0]) & (sb - 1);
            end
            nc: begin
                v = va;
                d = int'(b[DW-1:0]) & (2 * sb - 1);
            end
            default: v = '0;
        endcase
        hm = (W'(1) << d) >> 1;
        r.sh = v >>> d;
        r.half = |(v & hm);
        r.low = (d > 1) && |(v & (hm - W'(1)));
        return r;
    endfunction

    function automatic logic [ELEN:0] lane_s2(
        input raw_t r, input logic [3:0] o,
        input logic [1:0] s, input logic [1:0] rm);
        int sb;
        logic inc;
        logic sat;
        logic signed [W-1:0] v;
        logic signed [W-1:0] umax;
        logic signed [W-1:0] smax;
        logic signed [W-1:0] smin;
        sb = 8 << s;
        unique case (rm)
            2'd0:    inc = r.half;
            2'd1:    inc = r.half & (r.low | r.sh[0]);
            2'd2:    inc = 1'b0;
            default: inc = !r.sh[0] & (r.half | r.low);
        endcase
        v = $signed(r.sh) + $signed({{(W-1){1'b0}}, inc});
        umax = (W'(1) << sb) - W'(1);
        smax = (W'(1) << (sb - 1)) - W'(1);
        smin = -smax - W'(1);
        sat = 1'b0;
        if (o == SADDU || o == SSUBU || o == NCLIPU) begin
            if (v[W-1]) begin
                v = '0;
                sat = 1'b1;
            end else if (v > umax) begin
                v = umax;
                sat = 1'b1;
            end
        end else if (o == SADD || o == SSUB || o == SMUL || o == NCLIP) begin
            if (v > smax) begin
                v = smax;
                sat = 1'b1;
            end else if (v < smin) begin
                v = smin;
                sat = 1'b1;
            end
        end
        return {sat, ELEN'(v & umax)};
    endfunction

    state_t                state;
    logic [3:0]            op_q;
    logic [1:0]            sew_q;
    logic [1:0]            vxrm_q;
    logic [VL_W-1:0]       vl_q;
    logic                  vm_q;
    logic [VL_W-1:0]       beats;
    logic [EW-1:0]         elem;
    logic [VL_W:0]         vl_up;
    logic                  bad;
    logic                  stall;
    logic                  accept;
    logic                  sat_set;
    logic [LANES-1:0]      act;
    raw_t                  s1_in [LANES];
    logic                  s1_valid;
    logic [LANES-1:0]      s1_act;
    raw_t                  s1_raw [LANES];
    logic [LANES*ELEN-1:0] s1_old;
    logic [ELEN:0]         s2_r [LANES];
    logic [LANES*ELEN-1:0] s2_data;
    logic [LANES-1:0]      s2_sat;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = (state == RUN) & ~stall;
    assign accept   = in_valid & in_ready;
    assign sat_set  = ~stall & s1_valid & |s2_sat;
    assign vl_up    = {1'b0, vl} + (VL_W+1)'(LANES - 1);

    // Reject unsupported op / element-width combinations at launch.
    always_comb begin
        bad = (op > NCLIP) || (int'(sew) > SEW_MAX) ||
              ((op == NCLIP || op == NCLIPU) && ((8 << sew) == ELEN));
`ifndef FXP_SMUL_EN
        if (op == SMUL) bad = 1'b1;
`endif
    end

    // Stage 1: raw sum/product/shift plus rounding bits, and lane activity.
    always_comb begin
        act = '0;
        for (int l = 0; l < LANES; l++) begin
            s1_in[l] = lane_s1(in_a[l*ELEN +: ELEN], in_b[l*ELEN +: ELEN],
                               op_q, sew_q);
            act[l] = (elem + EW'(l) < {2'b00, vl_q}) && (vm_q || in_mask[l]);
        end
    end

    // Stage 2: round, saturate, and merge inactive lanes from old vd.
    always_comb begin
        s2_data = '0;
        s2_sat = '0;
        for (int l = 0; l < LANES; l++) begin
            s2_r[l] = lane_s2(s1_raw[l], op_q, sew_q, vxrm_q);
            s2_sat[l] = s1_act[l] & s2_r[l][ELEN];
            s2_data[l*ELEN +: ELEN] = s1_act[l] ? s2_r[l][ELEN-1:0]
                                                : s1_old[l*ELEN +: ELEN];
        end
    end

    // Two-stage pipeline; both stages freeze while the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_act <= '0;
            s1_old <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            for (int l = 0; l < LANES; l++) s1_raw[l] <= '0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_act <= act;
                s1_old <= in_old;
                for (int l = 0; l < LANES; l++) s1_raw[l] <= s1_in[l];
            end
            out_valid <= s1_valid;
            if (s1_valid) out_data <= s2_data;
        end
    end

    // Sticky saturation flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) vxsat <= 1'b0;
        else if (sat_set) vxsat <= 1'b1;
        else if (clr_vxsat) vxsat <= 1'b0;
    end

    // Instruction sequencer: launch, count beats, wait for the last transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            illegal <= 1'b0;
            op_q <= '0;
            sew_q <= '0;
            vxrm_q <= '0;
            vl_q <= '0;
            vm_q <= 1'b0;
            beats <= '0;
            elem <= '0;
        end else begin
            done <= 1'b0;
            illegal <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    op_q <= op;
                    sew_q <= sew;
                    vxrm_q <= vxrm;
                    vl_q <= vl;
                    vm_q <= vm;
                    elem <= '0;
                    if (bad) begin
                        illegal <= 1'b1;
                        done <= 1'b1;
                    end else if (vl == '0) begin
                        done <= 1'b1;
                    end else begin
                        state <= RUN;
                        busy <= 1'b1;
                        beats <= VL_W'(vl_up / (VL_W+1)'(LANES));
                    end
                end
                RUN: if (accept) begin
                    beats <= beats - VL_W'(1);
                    elem <= elem + EW'(LANES);
                    if (beats == VL_W'(1)) state <= DRAIN;
                end
                DRAIN: if (out_valid && out_ready && !s1_valid) begin
                    state <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
